// File: rtl/sub16_serial_pkg.sv
// -----------------------------------------------------------------------------
// sub16_serial_pkg
// Shared constants for the nibble-serial subtractor:
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - SLICE_BITS: number of operand bits handled per clock cycle
// -----------------------------------------------------------------------------
package sub16_serial_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam int SLICE_BITS = 4;

endpackage : sub16_serial_pkg

// File: rtl/sub4.sv
// -----------------------------------------------------------------------------
// sub4
// Purely combinational 4-bit subtract slice with lookahead borrow.
// Computes d = a - b - bin as a + ~b + ~bin; the borrow-out is the inverse of
// the carry-out of that addition.
// Ports:
//   a    [3:0] in   minuend nibble
//   b    [3:0] in   subtrahend nibble
//   bin        in   borrow from the next-lower slice
//   d    [3:0] out  difference nibble
//   bout       out  borrow into the next-higher slice
// -----------------------------------------------------------------------------
module sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate of the addition a + ~b.
    assign g = a & ~b;
    assign p = ~(a ^ b);

    // Every carry is expanded directly from g/p/c[0] so no bit waits on the
    // carry of its neighbour.
    assign c[0] = ~bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign d    = p ^ c[3:0];
    assign bout = ~c[4];

endmodule : sub4

// File: rtl/sub16_serial.sv
// -----------------------------------------------------------------------------
// sub16_serial
// Nibble-serial unsigned subtractor: diff = x - y - bin (mod 2^MAXN), one
// SLICE-bit slice per cycle, LSB slice first, through a single shared sub4.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, honoured only in IDLE or DONE
//   x, y [MAXN] in  minuend / subtrahend, captured with an accepted start
//   bin        in   borrow-in, captured with an accepted start
//   busy       out  high while slices are being processed
//   done       out  one-cycle pulse, result valid
//   diff [MAXN] out difference
//   bout       out  borrow-out (x < y + bin)
//   zero       out  diff == 0
// -----------------------------------------------------------------------------
module sub16_serial
    import sub16_serial_pkg::*;
#(
    parameter int MAXN  = 16,
    parameter int SLICE = SLICE_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [MAXN-1:0] x,
    input  logic [MAXN-1:0] y,
    input  logic            bin,
    output logic            busy,
    output logic            done,
    output logic [MAXN-1:0] diff,
    output logic            bout,
    output logic            zero
);

    localparam int NSL = MAXN / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MAXN-1:0] xa_q, xa_d;
    logic [MAXN-1:0] yb_q, yb_d;
    logic            brw_q, brw_d;
    logic [MAXN-1:0] diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            zero_q, zero_d;

    int              base;
    logic [SLICE-1:0] slice_a, slice_b, slice_d;
    logic            slice_bout;

    // The counter picks which slice of the latched operands feeds the slice.
    assign base    = int'(cnt_q) * SLICE;
    assign slice_a = xa_q[base +: SLICE];
    assign slice_b = yb_q[base +: SLICE];

    sub4 u_sub4 (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (brw_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xa_d    = xa_q;
        yb_d    = yb_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        case (state_q)
            ST_BUSY: begin
                diff_d[base +: SLICE] = slice_d;
                brw_d = slice_bout;
                cnt_d = cnt_q + 1'b1;
                // bout/zero keep the previous result until the final slice
                // lands; zero looks at the whole word including that slice.
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    bout_d  = slice_bout;
                    zero_d  = (diff_d == '0);
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    xa_d    = x;
                    yb_d    = y;
                    brw_d   = bin;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xa_q    <= '0;
            yb_q    <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xa_q    <= xa_d;
            yb_q    <= yb_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule : sub16_serial

// File: tb/tb_sub16_serial.sv
`timescale 1ns/1ps
module tb_sub16_serial;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bin   = 1'b0;
    logic [15:0] x     = '0;
    logic [15:0] y     = '0;
    logic        busy, done, bout, zero;
    logic [15:0] diff;

    typedef struct packed {
        logic [15:0] d;
        logic        b;
        logic        z;
    } res_t;

    res_t q[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    sub16_serial #(.MAXN(16), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] r;
        res_t        o;
        r   = {1'b0, a} - {1'b0, b} - {16'd0, c};
        o.d = r[15:0];
        o.b = r[16];
        o.z = (r[15:0] == 16'd0);
        return o;
    endfunction

    // Drive one request for a single edge (entered just after an edge),
    // push the expected result, then scramble the inputs.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c);
        x = a; y = b; bin = c; start = 1'b1;
        q.push_back(model(a, b, c));
        @(posedge clk); #1;
        start = 1'b0;
        x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom);
    endtask

    // Edges until done is seen high, -1 if it never comes.
    task automatic wait_done(output int n);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n = i;
                return;
            end
        end
        n = -1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({diff, bout, zero, busy, done} !== 19'd0) begin
            bad++;
            $display("FAIL reset_asserted got=%h want=0", {diff, bout, zero, busy, done});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({diff, bout, zero, busy, done} !== 19'd0) begin
            bad++;
            $display("FAIL reset_released got=%h want=0", {diff, bout, zero, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [15:0] xs [7];
        logic [15:0] ys [7];
        logic        bs [7];
        res_t        e;
        int          n;
        xs[0] = 16'h1234; ys[0] = 16'h0234; bs[0] = 1'b0;
        xs[1] = 16'h0000; ys[1] = 16'h0001; bs[1] = 1'b0;
        xs[2] = 16'h8000; ys[2] = 16'h7FFF; bs[2] = 1'b1;
        for (int i = 3; i < 7; i++) begin
            xs[i] = 16'($urandom); ys[i] = 16'($urandom); bs[i] = 1'($urandom);
        end
        for (int i = 0; i < 7; i++) begin
            issue(xs[i], ys[i], bs[i]);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_busy[%0d] got=%b want=1", i, busy);
            end
            wait_done(n);
            total++;
            if (n != 4) begin
                bad++;
                $display("FAIL basic_latency[%0d] got=%0d want=4", i, n);
            end
            e = 'x;
            if (q.size() != 0) e = q.pop_front();
            total++;
            if ({diff, bout, zero} !== e) begin
                bad++;
                $display("FAIL basic_result[%0d] got diff=%h bout=%b zero=%b want diff=%h bout=%b zero=%b",
                         i, diff, bout, zero, e.d, e.b, e.z);
            end
        end
    endtask

    task automatic test_hold();
        logic [17:0] held;
        held = {diff, bout, zero};
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({diff, bout, zero, busy, done} !== {held, 2'b00}) begin
            bad++;
            $display("FAIL idle_hold got=%h want=%h", {diff, bout, zero, busy, done}, {held, 2'b00});
        end
    endtask

    task automatic test_ignore_start();
        res_t e;
        int   n;
        issue(16'h00F0, 16'h000F, 1'b0);
        x = 16'hFFFF; y = 16'h0000; bin = 1'b0; start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done} !== 2'b10) begin
                bad++;
                $display("FAIL ignore_busy[%0d] got=%b want=10", i, {busy, done});
            end
        end
        start = 1'b0;
        wait_done(n);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL ignore_latency got=%0d want=1", n);
        end
        e = 'x;
        if (q.size() != 0) e = q.pop_front();
        total++;
        if ({diff, bout, zero} !== e) begin
            bad++;
            $display("FAIL ignore_result got diff=%h bout=%b want diff=%h bout=%b", diff, bout, e.d, e.b);
        end
    endtask

    task automatic test_reset_abort();
        res_t e;
        int   n;
        int   snap;
        issue(16'h1234, 16'h0234, 1'b0);
        void'(q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({diff, bout, zero, busy, done} !== 19'd0) begin
            bad++;
            $display("FAIL abort_clear got=%h want=0", {diff, bout, zero, busy, done});
        end
        snap = done_cnt;
        #2 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (done_cnt != snap || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done got dones=%0d busy=%b want dones=%0d busy=0", done_cnt, busy, snap);
        end
        // Release mid-cycle and request straight away: the next edge must take it.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        issue(16'h0005, 16'h0003, 1'b0);
        wait_done(n);
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL post_reset_latency got=%0d want=4", n);
        end
        e = 'x;
        if (q.size() != 0) e = q.pop_front();
        total++;
        if ({diff, bout, zero} !== e) begin
            bad++;
            $display("FAIL post_reset_result got diff=%h want diff=%h", diff, e.d);
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        int   n;
        issue(16'h1234, 16'h0234, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        x = 16'h0010; y = 16'h0020; bin = 1'b0; start = 1'b1;
        q.push_back(model(16'h0010, 16'h0020, 1'b0));
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done got=%b want=1", done);
        end
        e = 'x;
        if (q.size() != 0) e = q.pop_front();
        total++;
        if ({diff, bout, zero} !== e) begin
            bad++;
            $display("FAIL b2b_first_result got diff=%h want diff=%h", diff, e.d);
        end
        @(posedge clk); #1;
        start = 1'b0;
        x = 16'($urandom); y = 16'($urandom);
        total++;
        if ({busy, done} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_reaccept got=%b want=10", {busy, done});
        end
        wait_done(n);
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL b2b_latency got=%0d want=4", n);
        end
        e = 'x;
        if (q.size() != 0) e = q.pop_front();
        total++;
        if ({diff, bout, zero} !== e) begin
            bad++;
            $display("FAIL b2b_second_result got diff=%h bout=%b want diff=%h bout=%b", diff, bout, e.d, e.b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule : tb_sub16_serial
